hazard_sequencer: RTL and testbench

- Sequences stalls, bubbles and flushes for the five-stage pipeline, using signals from the ID-stage decode controller, the ID/EX register and the data-memory port.
- Drives the PC, IF/ID and EX/MEM write enables, plus the ID/EX bubble insert.
- Arbitrates three stall sources by fixed priority: data-memory wait, then load-use hazard, then control flush.
- Watches data-memory wait length and raises a sticky timeout error.

---
 rtl/hazard_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_hazard_sequencer.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/hazard_sequencer.sv
// hazard_sequencer: stall/bubble/flush sequencing for the five-stage pipeline.
// Priority: data-memory wait, then load-use hazard, then control flush.
// Raises a sticky timeout after MAX_WAIT consecutive data-memory wait cycles.
// Optional feature macro: HAZARD_PERF_EN enables the stall/flush counters;
// when it is undefined, stall_count and flush_count are tied to zero.
module hazard_sequencer #(
  parameter int MAX_WAIT = 15,
  parameter int WAIT_W   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic [4:0]  ex_rt,
  input  logic        ex_mem_read,
  input  logic [1:0]  flush_req,
  input  logic        dmem_req,
  input  logic        dmem_ready,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        exmem_hold,
  output logic        mem_timeout,
  output logic [1:0]  state,
  output logic [15:0] stall_count,
  output logic [15:0] flush_count
);

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_MEM_WAIT   = 2'd2
  } state_e;

  localparam logic [WAIT_W:0]   MAX_WAIT_C = (WAIT_W + 1)'(MAX_WAIT);
  localparam logic [WAIT_W-1:0] CNT_MAX_C  = {WAIT_W{1'b1}};

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              timeout_q, timeout_d;

  logic memwait_s;
  logic loaduse_s;
  logic waiting_s;
  logic loaduse_eff_s;
  logic pc_write_s, ifid_write_s, ifid_flush_s, idex_bubble_s, exmem_hold_s;
  logic [WAIT_W:0] cnt_inc_s;

  // Raw hazard detection; in MEM_WAIT only dmem_ready decides the freeze.
  always_comb begin
    memwait_s = dmem_req & ~dmem_ready;
    loaduse_s = ex_mem_read & (ex_rt != 5'd0) &
                ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));
    if (state_q == ST_MEM_WAIT) begin
      waiting_s = ~dmem_ready;
    end else begin
      waiting_s = memwait_s;
    end
    if (state_q == ST_LOAD_STALL) begin
      loaduse_eff_s = 1'b0;
    end else begin
      loaduse_eff_s = loaduse_s;
    end
  end

  // Prioritised control decision and next state; the MEM_WAIT release path
  // falls through to the RUN evaluation in the same cycle.
  always_comb begin
    pc_write_s    = 1'b1;
    ifid_write_s  = 1'b1;
    ifid_flush_s  = 1'b0;
    idex_bubble_s = 1'b0;
    exmem_hold_s  = 1'b0;
    state_d       = ST_RUN;
    if (waiting_s) begin
      pc_write_s   = 1'b0;
      ifid_write_s = 1'b0;
      exmem_hold_s = 1'b1;
      state_d      = ST_MEM_WAIT;
    end else if (loaduse_eff_s) begin
      pc_write_s    = 1'b0;
      ifid_write_s  = 1'b0;
      idex_bubble_s = 1'b1;
      state_d       = ST_LOAD_STALL;
    end else begin
      case (flush_req)
        2'b01: begin
          ifid_flush_s = 1'b1;
        end
        2'b10, 2'b11: begin
          ifid_flush_s  = 1'b1;
          idex_bubble_s = 1'b1;
        end
        default: begin
          ifid_flush_s  = 1'b0;
          idex_bubble_s = 1'b0;
        end
      endcase
    end
  end

  // Wait-length counter with saturation and sticky timeout flag.
  always_comb begin
    cnt_inc_s = {1'b0, wait_cnt_q} + {{WAIT_W{1'b0}}, 1'b1};
    timeout_d = timeout_q;
    if (waiting_s) begin
      if (wait_cnt_q == CNT_MAX_C) begin
        wait_cnt_d = wait_cnt_q;
      end else begin
        wait_cnt_d = cnt_inc_s[WAIT_W-1:0];
      end
      if (cnt_inc_s >= MAX_WAIT_C) begin
        timeout_d = 1'b1;
      end else begin
        timeout_d = timeout_q;
      end
    end else begin
      wait_cnt_d = {WAIT_W{1'b0}};
    end
  end

  // FSM state, wait counter and timeout flag registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= {WAIT_W{1'b0}};
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  // Output drive; reset forces the pipeline into a flushed, stalled state.
  always_comb begin
    if (!rst) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      exmem_hold  = 1'b0;
    end else begin
      pc_write    = pc_write_s;
      ifid_write  = ifid_write_s;
      ifid_flush  = ifid_flush_s;
      idex_bubble = idex_bubble_s;
      exmem_hold  = exmem_hold_s;
    end
  end

  assign mem_timeout = timeout_q;
  assign state       = state_q;

`ifdef HAZARD_PERF_EN
  logic [15:0] stall_cnt_q, flush_cnt_q;

  // Saturating counts of stalled cycles and IF/ID flush cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      if (!pc_write_s && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
      if (ifid_flush_s && (flush_cnt_q != 16'hFFFF)) begin
        flush_cnt_q <= flush_cnt_q + 16'd1;
      end
    end
  end

  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;
`else
  assign stall_count = 16'd0;
  assign flush_count = 16'd0;
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed scoreboard bench for hazard_sequencer.
module tb_hazard_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs, id_rt, ex_rt;
  logic        id_uses_rt, ex_mem_read, dmem_req, dmem_ready;
  logic [1:0]  flush_req;
  logic        pc_write, ifid_write, ifid_flush, idex_bubble, exmem_hold, mem_timeout;
  logic [1:0]  state;
  logic [15:0] stall_count, flush_count;

  int          n_vec  = 0;
  int          n_miss = 0;
  logic [7:0]  sb_q[$];
  logic [15:0] exp_stall = 16'd0;
  logic [15:0] exp_flush = 16'd0;

  always #5 clk = ~clk;

  hazard_sequencer #(.MAX_WAIT(15), .WAIT_W(4)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_rt(ex_rt), .ex_mem_read(ex_mem_read), .flush_req(flush_req),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready), .pc_write(pc_write),
    .ifid_write(ifid_write), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .exmem_hold(exmem_hold), .mem_timeout(mem_timeout), .state(state),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  // Packed expectation: {state, timeout, hold, bubble, flush, ifid_write, pc_write}
  function automatic logic [7:0] E(input logic [1:0] st, input logic to, input logic hold,
                                   input logic bub, input logic fl, input logic ifw,
                                   input logic pcw);
    return {st, to, hold, bub, fl, ifw, pcw};
  endfunction

  task automatic idle();
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0; ex_rt = 5'd0;
    ex_mem_read = 1'b0; flush_req = 2'b00; dmem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic step(input logic [7:0] expv);
    logic [7:0]  obs, want;
    logic [31:0] pobs, pwant;
    sb_q.push_back(expv);
    @(negedge clk);
    obs = {state, mem_timeout, exmem_hold, idex_bubble, ifid_flush, ifid_write, pc_write};
    n_vec++;
    if (sb_q.size() == 0) begin
      n_miss++;
      $error("FAIL scoreboard_empty: observed %b required an entry", obs);
    end else begin
      want = sb_q.pop_front();
      assert (obs === want) else begin
        n_miss++;
        $error("FAIL ctrl_v%0d: observed %b required %b", n_vec, obs, want);
      end
`ifdef HAZARD_PERF_EN
      pwant = {exp_stall, exp_flush};
`else
      pwant = 32'd0;
`endif
      pobs = {stall_count, flush_count};
      n_vec++;
      assert (pobs === pwant) else begin
        n_miss++;
        $error("FAIL perf_v%0d: observed %h required %h", n_vec, pobs, pwant);
      end
      if (!rst) begin
        exp_stall = 16'd0;
        exp_flush = 16'd0;
      end else begin
        if (!want[0] && exp_stall != 16'hFFFF) exp_stall = exp_stall + 16'd1;
        if (want[2] && exp_flush != 16'hFFFF) exp_flush = exp_flush + 16'd1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    idle();
    #1;
    // reset state
    step(E(2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    rst = 1'b1;
    step(E(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));

    // load-use on rs: one bubble, then LOAD_STALL cycle, then RUN
    ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
    step(E(2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    step(E(2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
    idle();
    step(E(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));

    // ex_rt == 0 never stalls
    ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
    step(E(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));

    // rt match ignored without id_uses_rt, stalls with it
    idle(); ex_mem_read = 1'b1; ex_rt = 5'd5; id_rt = 5'd5; id_rs = 5'd3;
    step(E(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
    id_uses_rt = 1'b1;
    step(E(2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    idle();
    step(E(2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));

    // branch, jump, and 11 treated as jump
    flush_req = 2'b01;
    step(E(2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1));
    flush_req = 2'b10;
    step(E(2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1));
    flush_req = 2'b11;
    step(E(2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1));
    idle();

    // memory wait of 3 cycles, release in the ready cycle
    dmem_req = 1'b1; dmem_ready = 1'b0;
    step(E(2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    step(E(2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    step(E(2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    dmem_ready = 1'b1;
    step(E(2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
    idle();
    step(E(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));

    // memwait + loaduse + branch: freeze first, then bubble, then flush
    dmem_req = 1'b1; dmem_ready = 1'b0;
    ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; flush_req = 2'b01;
    step(E(2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    step(E(2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    dmem_ready = 1'b1;
    step(E(2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    dmem_req = 1'b0;
    step(E(2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1));
    idle();
    step(E(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));

    // 15-cycle wait sets timeout after the 15th edge; stays set after release
    dmem_req = 1'b1; dmem_ready = 1'b0;
    for (int k = 0; k < 15; k++) begin
      step(E((k == 0) ? 2'd0 : 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    end
    step(E(2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    dmem_ready = 1'b1;
    step(E(2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
    idle();
    step(E(2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));

    // reset in the middle of a wait
    dmem_req = 1'b1; dmem_ready = 1'b0;
    step(E(2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    step(E(2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    rst = 1'b0;
    idle();
    step(E(2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    rst = 1'b1;
    step(E(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
